free_list: RTL and testbench

- Circular FIFO of free physical-register tags that feeds tag_PRF to the rename table in ID.
- On in-order commit, it takes back the tag displaced by the committed instruction (that instruction's tag_Rw_old).
- Keeps an architectural head pointer so that on stop (flush) every speculatively allocated tag returns to the list in one cycle, in step with the rename table's ARF_tag copy.

---
 rtl/free_list.sv | 116 +++++++++++
 tb/tb_free_list.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/free_list.sv
// Circular free list of physical-register tags with an architectural head for one-cycle flush recovery.
// Define FREE_LIST_CHECK_EN to build the in-list bitmap and the sticky err flag.
module free_list #(
  parameter int NUM_PREG = 16,
  parameter int NUM_AREG = 8,
  parameter int TAG_W    = 4,
  parameter int DEPTH    = NUM_PREG - NUM_AREG,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int CNT_W    = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stop,
  input  logic             alloc_req,
  output logic [TAG_W-1:0] tag_PRF,
  output logic             free_valid,
  output logic [CNT_W-1:0] free_count,
  input  logic             commit_valid,
  input  logic [TAG_W-1:0] commit_tag_old,
  output logic             err
);

  logic [TAG_W-1:0] entries_q [DEPTH];
  logic [TAG_W-1:0] entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] arch_head_q, arch_head_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             list_empty, list_full;
  logic             do_alloc, do_rel;

  // DEPTH need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign list_empty = (count_q == '0);
  assign list_full  = (count_q == CNT_W'(DEPTH));
  assign do_alloc   = alloc_req && !list_empty && !stop;
  assign do_rel     = commit_valid && !list_full;

  always_comb begin
    entries_d = entries_q;
    if (do_rel) entries_d[tail_q] = commit_tag_old;
    tail_d      = do_rel ? ptr_inc(tail_q) : tail_q;
    arch_head_d = do_rel ? ptr_inc(arch_head_q) : arch_head_q;
    // A same-cycle commit lands first, then head snaps to the updated arch_head.
    if (stop) begin
      head_d  = arch_head_d;
      count_d = CNT_W'(DEPTH);
    end else begin
      head_d  = do_alloc ? ptr_inc(head_q) : head_q;
      count_d = count_q + CNT_W'(do_rel) - CNT_W'(do_alloc);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= TAG_W'(NUM_AREG + i);
      head_q      <= '0;
      tail_q      <= '0;
      arch_head_q <= '0;
      count_q     <= CNT_W'(DEPTH);
    end else begin
      entries_q   <= entries_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      arch_head_q <= arch_head_d;
      count_q     <= count_d;
    end
  end

  assign tag_PRF    = entries_q[head_q];
  assign free_valid = !list_empty;
  assign free_count = count_q;

`ifdef FREE_LIST_CHECK_EN
  logic [NUM_PREG-1:0] in_list_q, in_list_d;
  logic                err_q, err_d;
  logic                tag_ok;

  assign tag_ok = ({1'b0, commit_tag_old} < (TAG_W+1)'(NUM_PREG));

  always_comb begin
    in_list_d = in_list_q;
    if (stop) begin
      // After recovery the list is full, so every entry lies between head and tail.
      in_list_d = '0;
      for (int i = 0; i < DEPTH; i++) in_list_d[entries_d[i]] = 1'b1;
    end else begin
      if (do_alloc) in_list_d[entries_q[head_q]] = 1'b0;
      if (do_rel && tag_ok) in_list_d[commit_tag_old] = 1'b1;
    end
    err_d = err_q
          | (commit_valid && !tag_ok)
          | (commit_valid && tag_ok && in_list_q[commit_tag_old])
          | (commit_valid && list_full)
          | (alloc_req && list_empty && !stop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PREG; i++) in_list_q[i] <= (i >= NUM_AREG);
      err_q <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      err_q     <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: a vector table for the alloc/empty/stop path plus hand-written multi-cycle sequences.
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst;
  logic       stop;
  logic       alloc_req;
  logic [3:0] tag_PRF;
  logic       free_valid;
  logic [3:0] free_count_lo;
  logic [4:0] free_count;
  logic       commit_valid;
  logic [3:0] commit_tag_old;
  logic       err;

`ifdef FREE_LIST_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  free_list dut (
    .clk           (clk),
    .rst           (rst),
    .stop          (stop),
    .alloc_req     (alloc_req),
    .tag_PRF       (tag_PRF),
    .free_valid    (free_valid),
    .free_count    (free_count),
    .commit_valid  (commit_valid),
    .commit_tag_old(commit_tag_old),
    .err           (err)
  );

  always #5 clk = ~clk;
  assign free_count_lo = free_count[3:0];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       alloc;
    logic       commit;
    logic [3:0] tag_old;
    logic       stp;
    logic [3:0] exp_tag;
    logic       exp_valid;
    logic [4:0] exp_count;
    logic       exp_err;   // value expected when checking is built in
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic a, input logic c, input logic [3:0] t, input logic s,
                     input logic [3:0] et, input logic ev, input logic [4:0] ec, input logic ee);
    vec_t v;
    v.alloc = a; v.commit = c; v.tag_old = t; v.stp = s;
    v.exp_tag = et; v.exp_valid = ev; v.exp_count = ec; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stop = 1'b0; alloc_req = 1'b0; commit_valid = 1'b0; commit_tag_old = 4'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic check_outputs(input string name, input logic [3:0] et, input logic ev,
                               input logic [4:0] ec, input logic ee);
    check({name, ".tag"},   32'(tag_PRF),    32'(et));
    check({name, ".valid"}, 32'(free_valid), 32'(ev));
    check({name, ".count"}, 32'(free_count), 32'(ec));
    check({name, ".err"},   32'(err),        32'(ee & CHK));
  endtask

  int         exp_order[8] = '{10, 11, 12, 13, 14, 15, 1, 2};
  logic [3:0] model_q[$];
  logic [3:0] exp_t;

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();
    check_outputs("reset", 4'd8, 1'b1, 5'd8, 1'b0);
    $display("reset tag=%0d count=%0d", tag_PRF, free_count);

    // Drain, over-allocate, release into empty, then flush twice.
    for (int i = 1; i <= 7; i++) add(1, 0, 0, 0, 4'(8 + i), 1, 5'(8 - i), 0);
    add(1, 0, 0, 0, 4'd8, 0, 5'd0, 0);
    add(1, 0, 0, 0, 4'd8, 0, 5'd0, 1);
    add(1, 1, 4'd3, 0, 4'd3, 1, 5'd1, 1);
    add(1, 0, 0, 0, 4'd9, 0, 5'd0, 1);
    add(0, 1, 4'd5, 0, 4'd5, 1, 5'd1, 1);
    add(1, 1, 4'd6, 0, 4'd6, 1, 5'd1, 1);
    add(0, 0, 0, 1, 4'd11, 1, 5'd8, 1);
    add(1, 0, 0, 1, 4'd11, 1, 5'd8, 1);
    add(1, 0, 0, 0, 4'd12, 1, 5'd7, 1);

    foreach (vecs[k]) begin
      alloc_req = vecs[k].alloc; commit_valid = vecs[k].commit;
      commit_tag_old = vecs[k].tag_old; stop = vecs[k].stp;
      step();
      check_outputs($sformatf("vec%0d", k), vecs[k].exp_tag, vecs[k].exp_valid,
                    vecs[k].exp_count, vecs[k].exp_err);
      $display("vec %0d alloc=%0d commit=%0d stop=%0d -> tag=%0d valid=%0d count=%0d err=%0d",
               k, vecs[k].alloc, vecs[k].commit, vecs[k].stp, tag_PRF, free_valid, free_count, err);
    end

    // Allocate 5, commit 1 and 2, flush; list order from head must be 10..15,1,2.
    do_reset();
    for (int i = 0; i < 5; i++) begin alloc_req = 1'b1; step(); end
    commit_valid = 1'b1; commit_tag_old = 4'd1; step();
    commit_valid = 1'b1; commit_tag_old = 4'd2; step();
    check("pre_stop.count", 32'(free_count), 32'd5);
    stop = 1'b1; step();
    check_outputs("post_stop", 4'd10, 1'b1, 5'd8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("order%0d", i), 32'(tag_PRF), 32'(exp_order[i]));
      $display("flush order %0d tag=%0d", i, tag_PRF);
      alloc_req = 1'b1; step();
    end
    check("order.empty", 32'(free_valid), 32'd0);

    // Release while full is dropped.
    do_reset();
    commit_valid = 1'b1; commit_tag_old = 4'd5; step();
    check_outputs("rel_full", 4'd8, 1'b1, 5'd8, 1'b1);
    $display("release-while-full count=%0d err=%0d", free_count, err);

    // Wrap: alternate alloc and release of 0..11 against a queue model.
    do_reset();
    model_q.delete();
    for (int i = 8; i < 16; i++) model_q.push_back(4'(i));
    for (int k = 0; k < 12; k++) begin
      exp_t = model_q.pop_front();
      check($sformatf("wrap%0d.tag", k), 32'(tag_PRF), 32'(exp_t));
      alloc_req = 1'b1; step();
      check($sformatf("wrap%0d.cnt_a", k), 32'(free_count), 32'(model_q.size()));
      commit_valid = 1'b1; commit_tag_old = 4'(k); step();
      model_q.push_back(4'(k));
      check($sformatf("wrap%0d.cnt_r", k), 32'(free_count), 32'(model_q.size()));
      $display("wrap %0d out=%0d in=%0d count=%0d", k, exp_t, k, free_count);
    end
    check("wrap.tail_tag", 32'(tag_PRF), 32'd4);
    check("wrap.err", 32'(err), 32'd0);

    // Double free of tag 9 while it is still listed; err holds until reset.
    do_reset();
    alloc_req = 1'b1; step();
    commit_valid = 1'b1; commit_tag_old = 4'd9; step();
    check_outputs("dfree", 4'd9, 1'b1, 5'd8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("dfree.hold%0d", i), 32'(err), 32'(CHK));
    end
    $display("double free err=%0d", err);
    #2 rst = 1'b0;
    #1;
    check_outputs("async_rst", 4'd8, 1'b1, 5'd8, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
